// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises and edge-detects peripheral lines into a
// W1C pending register, masks them, gates with IEN and reports the winning source.
module irq_ctrl #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               set_ien,
  input  logic               clear_ien,
  input  logic               reg_wr,
  input  logic [1:0]         reg_addr,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_SRC-1:0] sync1, sync2, prev;
  logic [NUM_SRC-1:0] pend, mask;
  logic [NUM_SRC-1:0] rise, act, pend_clr;
  logic               ien;
  logic [ID_W-1:0]    first_id;
  logic [15:0]        id_ext;
  logic               unused_bits;

  assign rise     = sync2 & ~prev;
  assign pend_clr = (reg_wr && reg_addr == 2'd0) ? reg_wdata[NUM_SRC-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      pend  <= '0;
      mask  <= '0;
      ien   <= 1'b0;
    end else begin
      sync1 <= src_irq;
      sync2 <= sync1;
      prev  <= sync2;
      // OR-ing rise after the clear lets a same-cycle new request survive W1C
      pend  <= (pend & ~pend_clr) | rise;
      if (reg_wr && reg_addr == 2'd1)
        mask <= reg_wdata[NUM_SRC-1:0];
      if (clear_ien)
        ien <= 1'b0;
      else if (set_ien)
        ien <= 1'b1;
    end
  end

  assign act = pend & mask;
  assign irq = ien & (|act);

  always_comb begin
    first_id = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (act[i-1])
        first_id = ID_W'(i - 1);
    end
  end

  assign irq_id = irq ? first_id : '0;
  assign id_ext = 16'(irq_id);

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata[NUM_SRC-1:0] = pend;
      2'd1: reg_rdata[NUM_SRC-1:0] = mask;
      2'd2: begin
        reg_rdata[0]    = ien;
        reg_rdata[1]    = irq;
        reg_rdata[11:8] = id_ext[3:0];
      end
      default: reg_rdata = '0;
    endcase
  end

  assign unused_bits = ^{reg_wdata, id_ext};

endmodule
